scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer_pkg.sv | 22 ++
 rtl/scan_sequencer_tick_counter.sv | 25 ++
 rtl/scan_sequencer.sv | 109 ++++++++++
 tb/tb_scan_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/scan_sequencer_pkg.sv
// Shared constants for the four-digit multiplexed display scanner:
// FSM state encoding, default slot timing and anode helpers.
package scan_sequencer_pkg;

  localparam int unsigned DEF_SHOW_CYCLES  = 100000;
  localparam int unsigned DEF_BLANK_CYCLES = 1000;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low one-cold anode pattern for a slot index.
  function automatic logic [3:0] an_drive(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

  function automatic logic [3:0] nibble_of(input logic [15:0] d, input logic [1:0] sel);
    return d[{sel, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/scan_sequencer_tick_counter.sv
// Slot timer: restartable counter that flags the cycle on which it
// reaches the programmed terminal value.
module tick_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == terminal);

endmodule

// File: rtl/scan_sequencer.sv
// Four-digit anode scanner with blanking dead-time and frame-synchronous
// double buffering of the displayed digits and enables.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = DEF_SHOW_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Digits,
  input  logic [3:0]  DigitEnable,
  input  logic        Load,
  output logic [3:0]  AN,
  output logic [1:0]  Selector,
  output logic [3:0]  DigitOut,
  output logic        FrameDone
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] SHOW_TERM  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_TERM = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

  // With no dead-time the scanner never visits BLANK, so it starts in SHOW.
  localparam logic [0:0] ST_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  logic [0:0]    state;
  logic [1:0]    sel;
  logic [3:0]    digit_out;
  logic [15:0]   disp_digits;
  logic [3:0]    disp_en;
  logic [15:0]   stg_digits;
  logic [3:0]    stg_en;
  logic          pending;

  logic          tc;
  logic          slot_end;
  logic          boundary;
  logic          commit;
  logic [1:0]    sel_next;
  logic [CW-1:0] terminal;

  assign terminal = (state == ST_SHOW) ? SHOW_TERM : BLANK_TERM;
  assign slot_end = (state == ST_SHOW) && tc;
  assign boundary = slot_end && (sel == 2'd3);
  assign commit   = boundary && pending;
  assign sel_next = sel + 2'd1;

  tick_counter #(
    .WIDTH (CW)
  ) u_tick (
    .clk      (Clk),
    .rst      (Reset),
    .load     (tc),
    .terminal (terminal),
    .tc       (tc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_START;
      sel         <= '0;
      digit_out   <= '0;
      disp_digits <= '0;
      disp_en     <= '0;
      stg_digits  <= '0;
      stg_en      <= '0;
      pending     <= 1'b0;
    end else begin
      // A Load on the boundary cycle wins over the commit clearing pending.
      if (Load) begin
        stg_digits <= Digits;
        stg_en     <= DigitEnable;
        pending    <= 1'b1;
      end else if (commit) begin
        pending    <= 1'b0;
      end

      if (commit) begin
        disp_digits <= stg_digits;
        disp_en     <= stg_en;
      end

      if ((state == ST_BLANK) && tc) begin
        state <= ST_SHOW;
      end

      if (slot_end) begin
        sel       <= sel_next;
        state     <= (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
        digit_out <= nibble_of(commit ? stg_digits : disp_digits, sel_next);
      end
    end
  end

  always_comb begin
    AN = AN_OFF;
    if (!Reset && (state == ST_SHOW) && disp_en[sel]) begin
      AN = an_drive(sel);
    end
  end

  assign FrameDone = boundary && !Reset;
  assign Selector  = sel;
  assign DigitOut  = digit_out;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed plus random check of scan_sequencer (SHOW=4, BLANK=2) against a
// cycle-position model: slot = (k/6)%4, frame = 24 cycles.
module tb_scan_sequencer;

  localparam int unsigned SHOW  = 4;
  localparam int unsigned BLANK = 2;
  localparam int unsigned SLOT  = SHOW + BLANK;
  localparam int unsigned FRAME = 4 * SLOT;

  logic        Clk;
  logic        Reset;
  logic [15:0] Digits;
  logic [3:0]  DigitEnable;
  logic        Load;
  logic [3:0]  AN;
  logic [1:0]  Selector;
  logic [3:0]  DigitOut;
  logic        FrameDone;

  scan_sequencer #(
    .SHOW_CYCLES  (SHOW),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Digits      (Digits),
    .DigitEnable (DigitEnable),
    .Load        (Load),
    .AN          (AN),
    .Selector    (Selector),
    .DigitOut    (DigitOut),
    .FrameDone   (FrameDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          ncmp;
  int          nfail;
  int          k;
  bit          valid;
  logic [15:0] m_disp_d;
  logic [3:0]  m_disp_e;
  logic [15:0] m_stg_d;
  logic [3:0]  m_stg_e;
  bit          m_pend;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs for that cycle, advance the model.
  task automatic step(input logic ld, input logic [15:0] dg, input logic [3:0] en, input logic rst);
    int          slot;
    bit          show;
    logic [3:0]  exp_an;
    logic        exp_fd;
    Load = ld; Digits = dg; DigitEnable = en; Reset = rst;
    #1;
    if (valid) begin
      slot   = (k / SLOT) % 4;
      show   = (k % SLOT) >= BLANK;
      exp_fd = !rst && ((k % FRAME) == FRAME - 1);
      exp_an = 4'hF;
      if (!rst && show && m_disp_e[slot]) exp_an[slot] = 1'b0;
      chk("AN", {4'h0, AN}, {4'h0, exp_an});
      chk("Selector", {6'h0, Selector}, 8'(slot));
      chk("DigitOut", {4'h0, DigitOut}, {4'h0, m_disp_d[slot*4 +: 4]});
      chk("FrameDone", {7'h0, FrameDone}, {7'h0, exp_fd});
    end
    chk("AN_onecold", {7'h0, ($countones(~AN) <= 1)}, 8'h01);
    @(posedge Clk);
    #1;
    if (rst) begin
      k = 0; valid = 1'b1;
      m_disp_d = '0; m_disp_e = '0; m_stg_d = '0; m_stg_e = '0; m_pend = 1'b0;
    end else if (valid) begin
      if (((k % FRAME) == FRAME - 1) && m_pend) begin
        m_disp_d = m_stg_d; m_disp_e = m_stg_e; m_pend = 1'b0;
      end
      if (ld) begin
        m_stg_d = dg; m_stg_e = en; m_pend = 1'b1;
      end
      k++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != pos; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    chk("run_to_bound", 8'(k % FRAME), 8'(pos));
  endtask

  initial begin
    ncmp = 0; nfail = 0; k = 0; valid = 1'b0;
    m_disp_d = '0; m_disp_e = '0; m_stg_d = '0; m_stg_e = '0; m_pend = 1'b0;
    Reset = 1'b1; Load = 1'b0; Digits = '0; DigitEnable = '0;
    @(posedge Clk);
    #1;

    step(1'b0, 16'h0, 4'h0, 1'b1);
    step(1'b0, 16'h0, 4'h0, 1'b1);
    idle(3);

    // Full walk with all digits enabled.
    step(1'b1, 16'h4321, 4'hF, 1'b0);
    run_to(0);
    idle(FRAME);

    // Alternate digits dark; frame length unchanged.
    run_to(7);
    step(1'b1, 16'h5678, 4'b1010, 1'b0);
    idle(2 * FRAME);

    // Mid-frame load, overwritten before commit.
    run_to(10);
    step(1'b1, 16'h9999, 4'hF, 1'b0);
    step(1'b1, 16'hAAAA, 4'hF, 1'b0);
    idle(FRAME + 4);

    // Load on the boundary cycle itself.
    run_to(FRAME - 1);
    step(1'b1, 16'h1234, 4'hF, 1'b0);
    idle(2 * FRAME);

    // Reset during SHOW of slot 2.
    run_to(15);
    step(1'b0, 16'h0, 4'h0, 1'b1);
    step(1'b0, 16'h0, 4'h0, 1'b1);
    idle(FRAME + 6);

    // Random loads and occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 8) == 0, 16'($urandom), 4'($urandom), ($urandom % 80) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
